mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage that sits directly downstream of the execute stage and upstream of write-back. It accepts an instruction over the valid/allowin handshake and waits for the data-SRAM response when that instruction issued a load or store request in execute. It buffers the response if write-back stalls, then extracts and extends load data and forwards the final result. It also drives the register-forwarding/stall bundle consumed by decode.

## Interface
Parameters: none. All widths come from the shared package.

Ports:
- clk  in  1  single clock; all state on its rising edge
- resetn  in  1  asynchronous reset, active-low
- mem_allowin  out  1  stage can accept a new instruction this cycle
- ex_to_mem_valid  in  1  execute presents a valid instruction
- ex_to_mem_bus  in  EX_TO_MEM_WIDTH (75)  {rf_we, rf_waddr[4:0], pc[31:0], alu_result[31:0], res_from_mem, ld_op[2:0], mem_req}
- wb_allowin  in  1  write-back can accept
- mem_to_wb_valid  out  1  result valid toward write-back
- mem_to_wb_bus  out  MEM_TO_WB_WIDTH (70)  {rf_we, rf_waddr[4:0], pc[31:0], final_result[31:0]}
- data_sram_data_ok  in  1  response for the outstanding request
- data_sram_rdata  in  32  response read data
- mem_rf_zip  out  39  {load_pending, rf_we&mem_valid, rf_waddr, final_result}

## Operation
- The input register captures ex_to_mem_bus when ex_to_mem_valid & mem_allowin.
- mem_valid is set to ex_to_mem_valid whenever mem_allowin is high.
- Response FSM, 2-bit state:
  - IDLE: no outstanding response.
  - WAIT: mem_valid & mem_req, data_ok not yet seen.
  - HOLD: response captured in rdata_buf, waiting for wb_allowin.
- FSM transitions:
  - IDLE->WAIT when an entry with mem_req=1 is latched.
  - WAIT->IDLE on data_ok & wb_allowin (the instruction leaves).
  - WAIT->HOLD on data_ok & ~wb_allowin; rdata_buf <= data_sram_rdata.
  - HOLD->IDLE when mem_to_wb_valid & wb_allowin.
  - On leaving, if a new mem_req entry is latched in the same cycle, the next state is WAIT, not IDLE.
- data_ok is ignored in IDLE and HOLD. Exactly one response arrives per mem_req, the earliest in the first cycle in MEM.
- mem_ready_go = ~mem_req | (state==WAIT & data_ok) | state==HOLD.
- Handshake outputs:
  - mem_allowin = ~mem_valid | mem_ready_go & wb_allowin.
  - mem_to_wb_valid = mem_valid & mem_ready_go.
- Stores use mem_req=1, res_from_mem=0. They wait for data_ok and discard the data.
- Raw data: raw = (state==HOLD) ? rdata_buf : data_sram_rdata.
- Load extraction uses addr = alu_result[1:0]:
  - ld_op 000 (W): raw.
  - 001 (B): byte raw[8*addr+:8], sign-extended.
  - 101 (BU): same byte, zero-extended.
  - 010 (H): half raw[16*addr[1]+:16], sign-extended.
  - 110 (HU): same half, zero-extended.
  - Other codes produce raw.
  - addr[0] is ignored for halves; alignment is enforced upstream.
- final_result = res_from_mem ? load_data : alu_result.
- load_pending = mem_valid & res_from_mem & ~mem_ready_go. Decode stalls on this bit rather than forwarding.

## Timing
- Reset (async assert, sync-deassert safe):
  - mem_valid=0, state=IDLE, rdata_buf=0, input register=0.
  - Outputs during reset: mem_allowin=1, mem_to_wb_valid=0, mem_rf_zip=0 in its valid bits.
- Latency:
  - Non-memory instruction: 1 cycle in MEM.
  - Memory instruction: leaves in the data_ok cycle if wb_allowin, otherwise in the first later cycle with wb_allowin.
- Back-to-back throughput is 1 per cycle when data_ok arrives in the first MEM cycle and wb_allowin=1.
- data_ok & ~wb_allowin in the same cycle captures the data; the rdata value must not be lost.
- Reset asserted mid-WAIT drops the instruction. A late data_ok after reset is ignored because state is IDLE.
- final_result and the bus are combinational from the register/buffer; no extra cycle.

## Structure
- The shared package holds:
  - EX_TO_MEM_WIDTH, MEM_TO_WB_WIDTH.
  - The ld_op encodings (LD_W, LD_B, LD_H, LD_BU, LD_HU).
  - The FSM state encodings.
  - The zip width (39).
- One sub-module, load_extract: combinational (raw, addr[1:0], ld_op) -> 32-bit result.

## Test plan
- ALU op, rf_we=1, waddr=5, alu_result=0x1234, wb_allowin=1 -> next cycle mem_to_wb_valid=1, final_result=0x1234, mem_allowin stays 1.
- ld.b, addr low bits 2'b11, data_ok in first cycle with rdata=0x80FF_0000 -> final_result=0xFFFF_FF80. Repeat with ld.bu -> 0x0000_0080.
- ld.h, addr=2, data_ok delayed 3 cycles, rdata=0x8001_7FFF:
  - Before data_ok: mem_allowin=0, load_pending=1.
  - At data_ok: final_result=0xFFFF_8001.
- ld.w, data_ok=1 with wb_allowin=0 for 2 cycles, rdata=0xDEAD_BEEF, rdata then changes to 0 -> state HOLD; on wb_allowin, final_result=0xDEAD_BEEF.
- Store (mem_req=1, res_from_mem=0) followed by an ALU op, data_ok on cycle 2 -> store leaves at data_ok; ALU op enters the same cycle and leaves the next.
- resetn=0 during WAIT, then data_ok pulses after release -> mem_to_wb_valid stays 0, state IDLE.

Source files
------------

// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_pkg
// Description : Shared widths, load-op encodings, response FSM states and the
//               execute->memory bus layout for the memory-access stage.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

    localparam int EX_TO_MEM_WIDTH = 75;
    localparam int MEM_TO_WB_WIDTH = 70;
    localparam int RF_ZIP_WIDTH    = 39;

    // Load operation encodings carried in ld_op.
    localparam logic [2:0] LD_W  = 3'b000;
    localparam logic [2:0] LD_B  = 3'b001;
    localparam logic [2:0] LD_H  = 3'b010;
    localparam logic [2:0] LD_BU = 3'b101;
    localparam logic [2:0] LD_HU = 3'b110;

    // Data-SRAM response tracking states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // no outstanding response
        ST_WAIT = 2'd1,   // request outstanding, data_ok not yet seen
        ST_HOLD = 2'd2    // response buffered, waiting for write-back
    } mem_state_e;

    // Field layout of the execute->memory bus, MSB first.
    typedef struct packed {
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] pc;
        logic [31:0] alu_result;
        logic        res_from_mem;
        logic [2:0]  ld_op;
        logic        mem_req;
    } ex_to_mem_t;

endpackage : mem_stage_pkg
`default_nettype wire

// File: rtl/mem_stage_load_extract.sv
`default_nettype none
// ============================================================================
// Module      : load_extract
// Description : Selects and extends the byte/half/word addressed by a load
//               from the raw 32-bit SRAM response.
// Revision    : 1.0 - initial release
// ============================================================================
module load_extract
    import mem_stage_pkg::*;
(
    input  logic [31:0] raw_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  ld_op_i,
    output logic [31:0] result_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Byte lane from both address bits; half lane from addr[1] only, since
    // misaligned halves are rejected before reaching this stage.
    assign w_byte = raw_i[8*addr_i +: 8];
    assign w_half = raw_i[16*addr_i[1] +: 16];

    // Extend the selected lane according to the load type.
    always_comb begin
        result_o = raw_i;
        case (ld_op_i)
            LD_B:    result_o = {{24{w_byte[7]}}, w_byte};
            LD_BU:   result_o = {24'd0, w_byte};
            LD_H:    result_o = {{16{w_half[15]}}, w_half};
            LD_HU:   result_o = {16'd0, w_half};
            default: result_o = raw_i;
        endcase
    end

endmodule : load_extract
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : Memory-access pipeline stage. Holds one instruction from
//               execute, waits for the data-SRAM response of loads/stores,
//               buffers it while write-back stalls, extends load data and
//               drives the forwarding/stall bundle for decode.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       resetn,
    output logic                       mem_allowin,
    input  logic                       ex_to_mem_valid,
    input  logic [EX_TO_MEM_WIDTH-1:0] ex_to_mem_bus,
    input  logic                       wb_allowin,
    output logic                       mem_to_wb_valid,
    output logic [MEM_TO_WB_WIDTH-1:0] mem_to_wb_bus,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    output logic [RF_ZIP_WIDTH-1:0]    mem_rf_zip
);

    mem_state_e  state_q, state_d;
    logic        mem_valid_q;
    ex_to_mem_t  bus_q;
    logic [31:0] rdata_buf_q, rdata_buf_d;

    logic        w_ready_go;
    logic        w_accept;
    logic        w_new_req;
    logic [31:0] w_raw;
    logic [31:0] w_load_data;
    logic [31:0] w_final_result;
    logic        w_load_pending;

    // The instruction may advance once its response is in hand (or it needs none).
    assign w_ready_go = ~bus_q.mem_req
                      | ((state_q == ST_WAIT) & data_sram_data_ok)
                      | (state_q == ST_HOLD);

    assign mem_allowin     = ~mem_valid_q | (w_ready_go & wb_allowin);
    assign mem_to_wb_valid = mem_valid_q & w_ready_go;

    assign w_accept  = ex_to_mem_valid & mem_allowin;
    assign w_new_req = w_accept & ex_to_mem_bus[0];

    // Valid bit follows execute whenever the stage can take a new entry.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_valid_q <= 1'b0;
        end else if (mem_allowin) begin
            mem_valid_q <= ex_to_mem_valid;
        end
    end

    // Input register captures the execute bus on an accepted handshake.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus_q <= '0;
        end else if (w_accept) begin
            bus_q <= ex_to_mem_bus;
        end
    end

    // Response FSM state and buffered read data.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            rdata_buf_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            rdata_buf_q <= rdata_buf_d;
        end
    end

    // Next-state logic; a departing instruction may be replaced by a new
    // request in the same cycle, which goes straight to WAIT.
    always_comb begin
        state_d     = state_q;
        rdata_buf_d = rdata_buf_q;
        case (state_q)
            ST_IDLE: begin
                if (w_new_req) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (data_sram_data_ok) begin
                    if (wb_allowin) begin
                        state_d = w_new_req ? ST_WAIT : ST_IDLE;
                    end else begin
                        state_d     = ST_HOLD;
                        rdata_buf_d = data_sram_rdata;
                    end
                end
            end
            ST_HOLD: begin
                if (mem_to_wb_valid & wb_allowin) begin
                    state_d = w_new_req ? ST_WAIT : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Once buffered, the SRAM bus is free to change; read from the buffer.
    assign w_raw = (state_q == ST_HOLD) ? rdata_buf_q : data_sram_rdata;

    load_extract u_load_extract (
        .raw_i    (w_raw),
        .addr_i   (bus_q.alu_result[1:0]),
        .ld_op_i  (bus_q.ld_op),
        .result_o (w_load_data)
    );

    assign w_final_result = bus_q.res_from_mem ? w_load_data : bus_q.alu_result;

    // A load still waiting for data cannot be forwarded; decode must stall.
    assign w_load_pending = mem_valid_q & bus_q.res_from_mem & ~w_ready_go;

    assign mem_to_wb_bus = {bus_q.rf_we, bus_q.rf_waddr, bus_q.pc, w_final_result};

    assign mem_rf_zip = {w_load_pending, bus_q.rf_we & mem_valid_q,
                         bus_q.rf_waddr, w_final_result};

endmodule : mem_stage
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Directed self-checking bench for mem_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic                       clk;
    logic                       resetn;
    logic                       mem_allowin;
    logic                       ex_to_mem_valid;
    logic [EX_TO_MEM_WIDTH-1:0] ex_to_mem_bus;
    logic                       wb_allowin;
    logic                       mem_to_wb_valid;
    logic [MEM_TO_WB_WIDTH-1:0] mem_to_wb_bus;
    logic                       data_sram_data_ok;
    logic [31:0]                data_sram_rdata;
    logic [RF_ZIP_WIDTH-1:0]    mem_rf_zip;

    int n_checks;
    int n_errors;

    mem_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .mem_allowin       (mem_allowin),
        .ex_to_mem_valid   (ex_to_mem_valid),
        .ex_to_mem_bus     (ex_to_mem_bus),
        .wb_allowin        (wb_allowin),
        .mem_to_wb_valid   (mem_to_wb_valid),
        .mem_to_wb_bus     (mem_to_wb_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .mem_rf_zip        (mem_rf_zip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [74:0] mk_bus(input logic we, input logic [4:0] wa,
                                           input logic [31:0] pc, input logic [31:0] alu,
                                           input logic rfm, input logic [2:0] op,
                                           input logic req);
        return {we, wa, pc, alu, rfm, op, req};
    endfunction

    // Drive all inputs on the falling edge, then settle before checks.
    task automatic drive(input logic v, input logic [74:0] b, input logic wba,
                         input logic dok, input logic [31:0] rd);
        @(negedge clk);
        ex_to_mem_valid   = v;
        ex_to_mem_bus     = b;
        wb_allowin        = wba;
        data_sram_data_ok = dok;
        data_sram_rdata   = rd;
        #1;
    endtask

    logic [74:0] b_alu, b_ldb, b_ldbu, b_ldh, b_ldhu, b_ldw, b_st, b_alu2, b_ld2;

    initial begin
        n_checks = 0;
        n_errors = 0;
        resetn            = 1'b0;
        ex_to_mem_valid   = 1'b0;
        ex_to_mem_bus     = '0;
        wb_allowin        = 1'b1;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'd0;

        b_alu  = mk_bus(1'b1, 5'd5,  32'h100, 32'h1234, 1'b0, LD_W,  1'b0);
        b_ldb  = mk_bus(1'b1, 5'd6,  32'h104, 32'h1003, 1'b1, LD_B,  1'b1);
        b_ldbu = mk_bus(1'b1, 5'd7,  32'h108, 32'h1003, 1'b1, LD_BU, 1'b1);
        b_ldh  = mk_bus(1'b1, 5'd8,  32'h10C, 32'h2002, 1'b1, LD_H,  1'b1);
        b_ldhu = mk_bus(1'b1, 5'd9,  32'h110, 32'h2002, 1'b1, LD_HU, 1'b1);
        b_ldw  = mk_bus(1'b1, 5'd10, 32'h114, 32'h3000, 1'b1, LD_W,  1'b1);
        b_st   = mk_bus(1'b0, 5'd0,  32'h118, 32'h4000, 1'b0, LD_W,  1'b1);
        b_alu2 = mk_bus(1'b1, 5'd11, 32'h11C, 32'h55,   1'b0, LD_W,  1'b0);
        b_ld2  = mk_bus(1'b1, 5'd12, 32'h120, 32'h5000, 1'b1, LD_W,  1'b1);

        // Reset state
        #2;
        check_eq("rst_allowin", 70'(mem_allowin), 70'd1);
        check_eq("rst_valid",   70'(mem_to_wb_valid), 70'd0);
        check_eq("rst_zip",     70'(mem_rf_zip), 70'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // ALU op passes in one cycle
        drive(1'b1, b_alu, 1'b1, 1'b0, 32'd0);
        check_eq("alu_allowin_empty", 70'(mem_allowin), 70'd1);
        drive(1'b0, '0, 1'b1, 1'b0, 32'd0);
        check_eq("alu_valid",   70'(mem_to_wb_valid), 70'd1);
        check_eq("alu_allowin", 70'(mem_allowin), 70'd1);
        check_eq("alu_wb_bus",  70'(mem_to_wb_bus), {1'b1, 5'd5, 32'h100, 32'h1234});
        check_eq("alu_zip",     70'(mem_rf_zip), 70'({1'b0, 1'b1, 5'd5, 32'h1234}));

        // ld.b then ld.bu back-to-back, data_ok in first cycle
        drive(1'b1, b_ldb, 1'b1, 1'b0, 32'd0);
        drive(1'b1, b_ldbu, 1'b1, 1'b1, 32'h80FF_0000);
        check_eq("ldb_valid",   70'(mem_to_wb_valid), 70'd1);
        check_eq("ldb_result",  70'(mem_to_wb_bus[31:0]), 70'h0FFFF_FF80);
        check_eq("ldb_allowin", 70'(mem_allowin), 70'd1);
        drive(1'b0, '0, 1'b1, 1'b1, 32'h80FF_0000);
        check_eq("ldbu_valid",  70'(mem_to_wb_valid), 70'd1);
        check_eq("ldbu_result", 70'(mem_to_wb_bus[31:0]), 70'h0000_0080);
        check_eq("ldbu_waddr",  70'(mem_to_wb_bus[68:64]), 70'd7);
        drive(1'b0, '0, 1'b1, 1'b0, 32'd0);
        check_eq("ldbu_drain_valid", 70'(mem_to_wb_valid), 70'd0);
        check_eq("ldbu_drain_state", 70'(dut.state_q), 70'(ST_IDLE));

        // ld.h with response delayed three cycles
        drive(1'b1, b_ldh, 1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0, 32'h1111_2222);
            check_eq("ldh_wait_allowin", 70'(mem_allowin), 70'd0);
            check_eq("ldh_wait_pending", 70'(mem_rf_zip[38]), 70'd1);
            check_eq("ldh_wait_valid",   70'(mem_to_wb_valid), 70'd0);
        end
        drive(1'b1, b_ldhu, 1'b1, 1'b1, 32'h8001_7FFF);
        check_eq("ldh_valid",   70'(mem_to_wb_valid), 70'd1);
        check_eq("ldh_result",  70'(mem_to_wb_bus[31:0]), 70'hFFFF_8001);
        check_eq("ldh_pending", 70'(mem_rf_zip[38]), 70'd0);
        drive(1'b0, '0, 1'b1, 1'b1, 32'h8001_7FFF);
        check_eq("ldhu_result", 70'(mem_to_wb_bus[31:0]), 70'h0000_8001);

        // ld.w with write-back stalled; buffered data must survive
        drive(1'b1, b_ldw, 1'b1, 1'b0, 32'd0);
        drive(1'b0, '0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        check_eq("ldw_ok_valid",   70'(mem_to_wb_valid), 70'd1);
        check_eq("ldw_ok_allowin", 70'(mem_allowin), 70'd0);
        check_eq("ldw_ok_result",  70'(mem_to_wb_bus[31:0]), 70'hDEAD_BEEF);
        drive(1'b0, '0, 1'b0, 1'b0, 32'd0);
        check_eq("ldw_hold_state",  70'(dut.state_q), 70'(ST_HOLD));
        check_eq("ldw_hold_result", 70'(mem_to_wb_bus[31:0]), 70'hDEAD_BEEF);
        drive(1'b0, '0, 1'b1, 1'b1, 32'd0);
        check_eq("ldw_rel_valid",   70'(mem_to_wb_valid), 70'd1);
        check_eq("ldw_rel_result",  70'(mem_to_wb_bus[31:0]), 70'hDEAD_BEEF);
        check_eq("ldw_rel_allowin", 70'(mem_allowin), 70'd1);
        drive(1'b0, '0, 1'b1, 1'b0, 32'd0);
        check_eq("ldw_done_state", 70'(dut.state_q), 70'(ST_IDLE));
        check_eq("ldw_done_valid", 70'(mem_to_wb_valid), 70'd0);

        // Store followed by ALU op; ALU enters in the store's data_ok cycle
        drive(1'b1, b_st, 1'b1, 1'b0, 32'd0);
        drive(1'b1, b_alu2, 1'b1, 1'b0, 32'h7777_7777);
        check_eq("st_wait_allowin", 70'(mem_allowin), 70'd0);
        check_eq("st_wait_pending", 70'(mem_rf_zip[38]), 70'd0);
        check_eq("st_wait_valid",   70'(mem_to_wb_valid), 70'd0);
        drive(1'b1, b_alu2, 1'b1, 1'b1, 32'h7777_7777);
        check_eq("st_valid",   70'(mem_to_wb_valid), 70'd1);
        check_eq("st_allowin", 70'(mem_allowin), 70'd1);
        check_eq("st_wb_bus",  70'(mem_to_wb_bus), {1'b0, 5'd0, 32'h118, 32'h4000});
        drive(1'b0, '0, 1'b1, 1'b0, 32'd0);
        check_eq("alu2_valid",  70'(mem_to_wb_valid), 70'd1);
        check_eq("alu2_result", 70'(mem_to_wb_bus[31:0]), 70'h55);
        check_eq("alu2_state",  70'(dut.state_q), 70'(ST_IDLE));
        drive(1'b0, '0, 1'b1, 1'b0, 32'd0);
        check_eq("alu2_drain", 70'(mem_to_wb_valid), 70'd0);

        // Reset during WAIT drops the instruction; late data_ok ignored
        drive(1'b1, b_ld2, 1'b1, 1'b0, 32'd0);
        drive(1'b0, '0, 1'b1, 1'b0, 32'd0);
        check_eq("rw_state_wait", 70'(dut.state_q), 70'(ST_WAIT));
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check_eq("rw_rst_valid",   70'(mem_to_wb_valid), 70'd0);
        check_eq("rw_rst_state",   70'(dut.state_q), 70'(ST_IDLE));
        check_eq("rw_rst_allowin", 70'(mem_allowin), 70'd1);
        @(negedge clk);
        resetn = 1'b1;
        drive(1'b0, '0, 1'b1, 1'b1, 32'hCAFE_F00D);
        check_eq("rw_late_valid", 70'(mem_to_wb_valid), 70'd0);
        drive(1'b0, '0, 1'b1, 1'b0, 32'd0);
        check_eq("rw_late_state", 70'(dut.state_q), 70'(ST_IDLE));
        check_eq("rw_late_valid2", 70'(mem_to_wb_valid), 70'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mem_stage
`default_nettype wire
